conv_psum_accum: RTL and testbench

//  Multi-channel partial-sum accumulator between the conv engine and the FC stage.

---
 rtl/conv_psum_accum.sv | 206 ++++++++++++++++++++
 tb/tb_conv_psum_accum.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_accum.sv
// Multi-channel partial-sum accumulator: sums NUM_CH conv passes per pixel into a
// ROWSxCOLS buffer, then requantises and streams the map out over valid/ready.
module conv_psum_accum #(
   parameter int  ROWS   = 12,
   parameter int  COLS   = 11,
   parameter int  DIN_W  = 24,
   parameter int  ACC_W  = 32,
   parameter int  Q_W    = 8,
   parameter int  NUM_CH = 10,
   parameter int  SH_W   = 5,
   localparam int DEPTH  = ROWS * COLS,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = $clog2(NUM_CH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    in_valid,
   input  logic [AW-1:0]           in_addr,
   input  logic signed [DIN_W-1:0] in_data,
   input  logic                    ch_done,
   input  logic [SH_W-1:0]         shift,
   input  logic                    relu_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [Q_W-1:0]   out_data,
   output logic [AW-1:0]           out_addr,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done,
   output logic [CW-1:0]           ch_cnt,
   output logic                    err_addr
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN} state_t;

   localparam logic [AW-1:0]           LAST_ADDR = AW'(DEPTH - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W:0]   Q_MAX     = {{(ACC_W+2-Q_W){1'b0}}, {(Q_W-1){1'b1}}};
   localparam logic signed [ACC_W:0]   Q_MIN     = {{(ACC_W+2-Q_W){1'b1}}, {(Q_W-1){1'b0}}};

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [DIN_W-1:0] b);
      logic signed [ACC_W:0] s;
      s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W+1-DIN_W){b[DIN_W-1]}}, b});
      if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
      return s[ACC_W-1:0];
   endfunction

   // One extra bit keeps the round-half-up bias from wrapping near ACC_MAX.
   function automatic logic signed [ACC_W:0] rnd_shift(input logic signed [ACC_W-1:0] a,
                                                       input logic [SH_W-1:0] sh);
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] bias;
      ext  = $signed({a[ACC_W-1], a});
      bias = '0;
      if (sh != '0) bias = (ACC_W+1)'(1) << (sh - SH_W'(1));
      return (ext + bias) >>> sh;
   endfunction

   function automatic logic signed [Q_W-1:0] sat_q(input logic signed [ACC_W:0] r,
                                                   input logic relu);
      if (relu && r[ACC_W]) return '0;
      if (r > Q_MAX) return Q_MAX[Q_W-1:0];
      if (r < Q_MIN) return Q_MIN[Q_W-1:0];
      return r[Q_W-1:0];
   endfunction

   logic signed [ACC_W-1:0] mem [DEPTH];

   state_t                 state_q, state_d;
   logic [AW-1:0]          clr_cnt_q, clr_cnt_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          ch_cnt_q, ch_cnt_d;
   logic                   err_q, err_d;
   logic                   out_valid_q, out_valid_d;
   logic signed [Q_W-1:0]  out_data_q, out_data_d;
   logic [AW-1:0]          out_addr_q, out_addr_d;
   logic                   out_last_q, out_last_d;
   logic                   done_q, done_d;
   logic [SH_W-1:0]        shift_q, shift_d;
   logic                   relu_q, relu_d;

   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic signed [ACC_W-1:0] wr_data;

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      ch_cnt_d    = ch_cnt_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      shift_d     = shift_q;
      relu_d      = relu_q;
      wr_en       = 1'b0;
      wr_addr     = in_addr;
      wr_data     = sat_acc(mem[in_addr], in_data);

      if (clear) begin
         state_d     = S_CLEAR;
         clr_cnt_d   = '0;
         ch_cnt_d    = '0;
         err_d       = 1'b0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_addr_d  = '0;
         out_last_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_CLEAR: begin
               wr_en   = 1'b1;
               wr_addr = clr_cnt_q;
               wr_data = '0;
               if (clr_cnt_q == LAST_ADDR) state_d = S_ACCUM;
               else                        clr_cnt_d = clr_cnt_q + AW'(1);
            end
            S_ACCUM: begin
               // Read-modify-write through an async-read buffer, so a write lands
               // before the next cycle's read and back-to-back hits need no bypass.
               if (in_valid) begin
                  if (in_addr > LAST_ADDR) err_d = 1'b1;
                  else                     wr_en = 1'b1;
               end
               if (ch_done) begin
                  ch_cnt_d = ch_cnt_q + CW'(1);
                  if (ch_cnt_q == CW'(NUM_CH - 1)) begin
                     state_d  = S_DRAIN;
                     rd_ptr_d = '0;
                     shift_d  = shift;
                     relu_d   = relu_en;
                  end
               end
            end
            S_DRAIN: begin
               if (out_valid_q && out_ready && out_last_q) begin
                  state_d     = S_IDLE;
                  done_d      = 1'b1;
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_addr_d  = '0;
                  out_last_d  = 1'b0;
               end else if (!out_valid_q || out_ready) begin
                  out_valid_d = 1'b1;
                  out_data_d  = sat_q(rnd_shift(mem[rd_ptr_q], shift_q), relu_q);
                  out_addr_d  = rd_ptr_q;
                  out_last_d  = (rd_ptr_q == LAST_ADDR);
                  rd_ptr_d    = rd_ptr_q + AW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         clr_cnt_q   <= '0;
         rd_ptr_q    <= '0;
         ch_cnt_q    <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         ch_cnt_q    <= ch_cnt_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         shift_q     <= shift_d;
         relu_q      <= relu_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign ch_cnt    = ch_cnt_q;
   assign err_addr  = err_q;

endmodule

// File: tb/tb_conv_psum_accum.sv
// Directed bench for conv_psum_accum: a reference accumulator model fills a
// scoreboard queue when each accumulation closes; drained pixels are popped and compared.
module tb_conv_psum_accum;

   localparam int DEPTH = 132;
   localparam int AW    = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic [AW-1:0]     in_addr = '0;
   logic signed [23:0] in_data = '0;
   logic              ch_done = 1'b0;
   logic [4:0]        shift = '0;
   logic              relu_en = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic signed [7:0] out_data;
   logic [AW-1:0]     out_addr;
   logic              out_last;
   logic              busy;
   logic              done;
   logic [3:0]        ch_cnt;
   logic              err_addr;

   conv_psum_accum dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_addr(in_addr),
      .in_data(in_data), .ch_done(ch_done), .shift(shift), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
      .ch_cnt(ch_cnt), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
      bit last;
   } exp_t;

   exp_t   sb[$];
   longint m [DEPTH];
   bit     err_exp;
   int     checks = 0;
   int     errors = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint sat_acc_m(input longint v);
      if (v > 64'sd2147483647)  return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   function automatic int rq(input longint a, input int sh, input bit relu);
      longint r;
      r = (sh == 0) ? a : ((a + (longint'(1) << (sh - 1))) >>> sh);
      if (relu && r < 0) r = 0;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return int'(r);
   endfunction

   task automatic px(input int a, input int d, input bit cd);
      in_valid = 1'b1;
      in_addr  = a[AW-1:0];
      in_data  = d[23:0];
      ch_done  = cd;
      if (a < DEPTH) m[a] = sat_acc_m(m[a] + d);
      else           err_exp = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      ch_done  = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m[i] = 0;
      err_exp = 1'b0;
   endtask

   task automatic start_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_clear();
      repeat (DEPTH) @(negedge clk);
   endtask

   // Called at the DRAIN entry cycle, right after the closing ch_done is taken.
   task automatic load_sb();
      exp_t e;
      for (int i = 0; i < DEPTH; i++) begin
         e.addr = i;
         e.data = rq(m[i], int'(shift), relu_en);
         e.last = (i == DEPTH - 1);
         sb.push_back(e);
      end
      check("entry_vld", out_valid, 0);
      check("entry_busy", busy, 1);
   endtask

   task automatic drain(input bit rnd, input int stop_after);
      int   n = 0;
      int   cyc = 0;
      bit   stall = 1'b0;
      int   hd = 0;
      int   ha = 0;
      int   hl = 0;
      exp_t e;
      while (n < stop_after && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("first_vld", out_valid, 1);
         if (stall) begin
            check("hold_vld", out_valid, 1);
            check("hold_data", out_data, hd);
            check("hold_addr", out_addr, ha);
            check("hold_last", out_last, hl);
         end
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               check("px_data", out_data, e.data);
               check("px_addr", out_addr, e.addr);
               check("px_last", out_last, e.last);
            end
            n++;
         end
         stall = out_valid && !out_ready;
         hd = int'(out_data);
         ha = int'(out_addr);
         hl = int'(out_last);
      end
      if (n < stop_after) check("drain_timeout", n, stop_after);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic finish_drain();
      check("done_pulse", done, 1);
      check("idle_busy", busy, 0);
      check("sb_left", sb.size(), 0);
      @(negedge clk);
      check("done_low", done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      @(negedge clk);
      check("rst_vld", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_chcnt", ch_cnt, 0);
      check("rst_err", err_addr, 0);
      rst = 1'b0;
      @(negedge clk);

      // T1: every pixel gets 1 per pass
      start_clear();
      check("t1_busy", busy, 1);
      shift = 5'd0; relu_en = 1'b0;
      for (int p = 1; p <= 10; p++)
         for (int a = 0; a < DEPTH; a++) px(a, 1, a == DEPTH - 1);
      load_sb();
      drain(1'b0, DEPTH);
      finish_drain();
      check("t1_chcnt_hold", ch_cnt, 10);

      // T2 relu / T4 back-to-back / T5 err_addr + random stalls
      start_clear();
      check("clr_chcnt", ch_cnt, 0);
      shift = 5'd0; relu_en = 1'b1;
      px(0, -5, 0); px(1, 100, 0); px(2, -100, 0); px(131, 1, 0);
      px(5, 3, 0); px(5, 4, 0); px(5, 7, 1);
      check("t4_chcnt", ch_cnt, 1);
      for (int p = 2; p <= 10; p++) begin
         px(0, -5, 0); px(1, 100, 0); px(2, -100, 0);
         if (p == 2) begin
            px(200, 9, 0);
            check("t5_err", err_addr, err_exp);
         end
         px(131, 1, 1);
      end
      load_sb();
      drain(1'b1, DEPTH);
      finish_drain();

      // T2 without relu, T3 saturation at shift 0
      start_clear();
      check("clr_err", err_addr, 0);
      shift = 5'd0; relu_en = 1'b0;
      for (int p = 1; p <= 10; p++) begin
         px(0, -5, 0); px(1, 100, 0); px(2, -100, 0); px(131, 1, 1);
      end
      load_sb();
      drain(1'b0, DEPTH);
      finish_drain();

      // T3 rounding at shift 2, then T6 abort mid-drain
      start_clear();
      shift = 5'd2; relu_en = 1'b0;
      px(0, 6, 0); px(1, 5, 0); px(2, -6, 0); px(3, 10, 0); px(4, -10, 0); px(6, 1000, 0);
      px(131, 1, 1);
      for (int p = 2; p <= 10; p++) px(131, 1, 1);
      load_sb();
      drain(1'b1, 20);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("abort_vld", out_valid, 0);
      check("abort_busy", busy, 1);
      check("abort_chcnt", ch_cnt, 0);
      sb.delete();
      model_clear();
      repeat (DEPTH - 1) @(negedge clk);
      // last CLEAR cycle: this sample must be ignored
      in_valid = 1'b1; in_addr = '0; in_data = 24'sd77;
      @(negedge clk);
      in_valid = 1'b0;
      shift = 5'd1; relu_en = 1'b1;
      px(0, 3, 0); px(7, -3, 0); px(9, 1, 0); px(131, 2, 1);
      for (int p = 2; p <= 10; p++) begin
         px(0, 3, 0); px(7, -3, 0); px(131, 2, 1);
      end
      load_sb();
      drain(1'b1, DEPTH);
      finish_drain();

      // T6: async reset mid-ACCUM
      start_clear();
      px(3, 1, 0); px(250, 1, 0); px(3, 1, 1);
      check("pre_rst_chcnt", ch_cnt, 1);
      check("pre_rst_err", err_addr, 1);
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_chcnt", ch_cnt, 0);
      check("arst_err", err_addr, 0);
      check("arst_vld", out_valid, 0);
      check("arst_data", out_data, 0);
      check("arst_addr", out_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
